// File: rtl/reception_pkg.sv
// reception_pkg: shared types and codes for the reception scheduler.
//   - query codes carried by each arrival
//   - doctor identifiers used on assign_doc
//   - waiting-queue entry layout
package reception_pkg;

  localparam logic [1:0] QRY_GENERAL = 2'b00;  // any doctor, A preferred
  localparam logic [1:0] QRY_A       = 2'b01;
  localparam logic [1:0] QRY_B       = 2'b10;
  localparam logic [1:0] QRY_RSVD    = 2'b11;

  localparam logic DOC_A = 1'b0;
  localparam logic DOC_B = 1'b1;

  // The token field is sized for the widest token the block supports, so the
  // entry layout does not depend on the instance's TOKEN_W. Instances store
  // their token zero-extended and truncate it back on read.
  localparam int TOKEN_MAX_W = 16;

  typedef struct packed {
    logic [1:0]             query;
    logic [TOKEN_MAX_W-1:0] token;
  } entry_t;

endpackage

// File: rtl/reception_scheduler_doctor_timer.sv
// doctor_timer: consultation occupancy counter for one doctor.
//   clk, rst_n : clock and synchronous active-low reset
//   start      : dispatch to this doctor at this edge; loads CONSULT_CYCLES
//   busy       : registered, high while the countdown is non-zero
module doctor_timer #(
  parameter int CONSULT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  localparam int TW = $clog2(CONSULT_CYCLES + 1);
  localparam logic [TW-1:0] LOAD = TW'(CONSULT_CYCLES);

  logic [TW-1:0] timer;

  // busy tracks (timer != 0) of the value being written, so it stays a
  // register while matching the countdown exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      timer <= LOAD;
      busy  <= 1'b1;
    end else begin
      if (timer != '0) timer <= timer - 1'b1;
      busy <= (timer > TW'(1));
    end
  end

endmodule

// File: rtl/reception_scheduler.sv
// reception_scheduler: shares doctors A and B between arriving patients.
//   Arrivals get a token and join an in-order queue; the registered queue head
//   is dispatched to an eligible free doctor (strict FIFO, head-of-line
//   blocking). Per-doctor timers model consultation occupancy.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   arrive, query        : arrival pulse and query code
//   on_duty_a/b          : doctor may take new assignments
//   token, accept, reject: arrival result (registered)
//   assign_valid/doc/token: dispatch result (registered)
//   busy_a/b             : doctor in consultation
//   queue_count          : entries waiting
module reception_scheduler
  import reception_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TOKEN_W        = 4,   // must not exceed TOKEN_MAX_W
  parameter int CONSULT_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       arrive,
  input  logic [1:0]                 query,
  input  logic                       on_duty_a,
  input  logic                       on_duty_b,
  output logic [TOKEN_W-1:0]         token,
  output logic                       accept,
  output logic                       reject,
  output logic                       assign_valid,
  output logic                       assign_doc,
  output logic [TOKEN_W-1:0]         assign_token,
  output logic                       busy_a,
  output logic                       busy_b,
  output logic [$clog2(DEPTH):0]     queue_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  entry_t             mem [DEPTH];
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [TOKEN_W-1:0] next_token;

  logic push, pop, pop_doc;
  logic elig_a, elig_b;
  logic start_a, start_b;

  assign head = mem[rd_ptr];

  // Fullness is judged on the count before the edge, so a same-edge dispatch
  // never makes room for the arrival.
  assign push = arrive && (query != QRY_RSVD) && (queue_count != FULL);

  assign elig_a = !busy_a && on_duty_a;
  assign elig_b = !busy_b && on_duty_b;

  always_comb begin
    pop     = 1'b0;
    pop_doc = DOC_A;
    if (queue_count != '0) begin
      case (head.query)
        QRY_A: pop = elig_a;
        QRY_B: begin
          pop     = elig_b;
          pop_doc = DOC_B;
        end
        QRY_GENERAL: begin
          if (elig_a) begin
            pop = 1'b1;
          end else if (elig_b) begin
            pop     = 1'b1;
            pop_doc = DOC_B;
          end
        end
        default: pop = 1'b0;
      endcase
    end
  end

  assign start_a = pop && (pop_doc == DOC_A);
  assign start_b = pop && (pop_doc == DOC_B);

  // Queue storage needs no reset: entries are only read while queue_count
  // says they are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{query: query, token: TOKEN_MAX_W'(next_token)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      queue_count  <= '0;
      next_token   <= '0;
      token        <= '0;
      accept       <= 1'b0;
      reject       <= 1'b0;
      assign_valid <= 1'b0;
      assign_doc   <= 1'b0;
      assign_token <= '0;
    end else begin
      accept       <= push;
      reject       <= arrive && !push;
      assign_valid <= pop;

      if (push) begin
        wr_ptr     <= wr_ptr + 1'b1;
        token      <= next_token;
        next_token <= next_token + 1'b1;
      end

      if (pop) begin
        rd_ptr       <= rd_ptr + 1'b1;
        assign_doc   <= pop_doc;
        assign_token <= TOKEN_W'(head.token);
      end

      case ({push, pop})
        2'b10:   queue_count <= queue_count + 1'b1;
        2'b01:   queue_count <= queue_count - 1'b1;
        default: queue_count <= queue_count;
      endcase
    end
  end

  doctor_timer #(.CONSULT_CYCLES(CONSULT_CYCLES)) u_timer_a (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_a),
    .busy  (busy_a)
  );

  doctor_timer #(.CONSULT_CYCLES(CONSULT_CYCLES)) u_timer_b (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_b),
    .busy  (busy_b)
  );

endmodule

// File: tb/tb_reception_scheduler.sv
module tb_reception_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arrive;
  logic [1:0] query;
  logic       on_duty_a, on_duty_b;
  logic [3:0] token;
  logic       accept, reject;
  logic       assign_valid, assign_doc;
  logic [3:0] assign_token;
  logic       busy_a, busy_b;
  logic [2:0] queue_count;

  int n_chk  = 0;
  int n_fail = 0;

  reception_scheduler #(.DEPTH(4), .TOKEN_W(4), .CONSULT_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arrive       (arrive),
    .query        (query),
    .on_duty_a    (on_duty_a),
    .on_duty_b    (on_duty_b),
    .token        (token),
    .accept       (accept),
    .reject       (reject),
    .assign_valid (assign_valid),
    .assign_doc   (assign_doc),
    .assign_token (assign_token),
    .busy_a       (busy_a),
    .busy_b       (busy_b),
    .queue_count  (queue_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle; outputs then reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arr(input logic [1:0] q);
    arrive = 1'b1;
    query  = q;
  endtask

  initial begin
    rst_n = 1'b0; arrive = 1'b0; query = 2'b00;
    on_duty_a = 1'b1; on_duty_b = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_token", token, 0);
    chk("rst_count", queue_count, 0);
    chk("rst_accept", accept, 0);
    chk("rst_valid", assign_valid, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_busy_b", busy_b, 0);

    // Single general arrival: accept, dispatch to A one edge later, 4 busy cycles.
    arr(2'b00); tick(); arrive = 1'b0;
    chk("t1_accept", accept, 1);
    chk("t1_token", token, 0);
    chk("t1_count", queue_count, 1);
    chk("t1_no_early_assign", assign_valid, 0);
    tick();
    chk("t1_valid", assign_valid, 1);
    chk("t1_doc", assign_doc, 0);
    chk("t1_atok", assign_token, 0);
    chk("t1_busy_a0", busy_a, 1);
    chk("t1_count0", queue_count, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_busy_a_hold", busy_a, 1);
      chk("t1_valid_pulse", assign_valid, 0);
    end
    tick();
    chk("t1_busy_a_drop", busy_a, 0);

    // Back-to-back general arrivals: token 1 -> A, token 2 -> B.
    arr(2'b00); tick();
    chk("t2_tok1", token, 1);
    tick(); arrive = 1'b0;
    chk("t2_tok2", token, 2);
    chk("t2_valid1", assign_valid, 1);
    chk("t2_doc1", assign_doc, 0);
    chk("t2_atok1", assign_token, 1);
    tick();
    chk("t2_valid2", assign_valid, 1);
    chk("t2_doc2", assign_doc, 1);
    chk("t2_atok2", assign_token, 2);
    chk("t2_overlap_a", busy_a, 1);
    chk("t2_overlap_b", busy_b, 1);
    repeat (6) tick();
    chk("t2_idle_a", busy_a, 0);
    chk("t2_idle_b", busy_b, 0);

    // Head-of-line blocking: A-only entry waits behind busy A, B entry behind it.
    arr(2'b01); tick();
    chk("t3_tok3", token, 3);
    arr(2'b01); tick();
    chk("t3_assign3", assign_token, 3);
    chk("t3_valid3", assign_valid, 1);
    chk("t3_tok4", token, 4);
    arr(2'b10); tick(); arrive = 1'b0;
    chk("t3_tok5", token, 5);
    chk("t3_blocked_e3", assign_valid, 0);
    chk("t3_count2", queue_count, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_blocked", assign_valid, 0);
    end
    chk("t3_busy_a_low", busy_a, 0);
    chk("t3_count_hold", queue_count, 2);
    tick();
    chk("t3_valid4", assign_valid, 1);
    chk("t3_doc4", assign_doc, 0);
    chk("t3_atok4", assign_token, 4);
    tick();
    chk("t3_valid5", assign_valid, 1);
    chk("t3_doc5", assign_doc, 1);
    chk("t3_atok5", assign_token, 5);
    chk("t3_count0", queue_count, 0);
    repeat (6) tick();

    // Nobody on duty: reserved query rejected, queue fills at 4, fifth rejected.
    on_duty_a = 1'b0; on_duty_b = 1'b0;
    arr(2'b11); tick();
    chk("t4_rsvd_reject", reject, 1);
    chk("t4_rsvd_accept", accept, 0);
    chk("t4_rsvd_count", queue_count, 0);
    for (int i = 0; i < 4; i++) begin
      arr(2'b00); tick();
      chk("t4_fill_accept", accept, 1);
      chk("t4_fill_token", token, 6 + i);
      chk("t4_fill_count", queue_count, i + 1);
    end
    arr(2'b00); tick();
    chk("t4_full_reject", reject, 1);
    chk("t4_full_accept", accept, 0);
    chk("t4_full_count", queue_count, 4);
    chk("t4_token_held", token, 9);
    arr(2'b11); tick();
    chk("t4_rsvd_full_reject", reject, 1);

    // Full queue, dispatch and arrival on the same edge: arrival still refused.
    on_duty_a = 1'b1;
    arr(2'b00); tick(); arrive = 1'b0; on_duty_a = 1'b0;
    chk("t5_reject", reject, 1);
    chk("t5_valid", assign_valid, 1);
    chk("t5_atok", assign_token, 6);
    chk("t5_count", queue_count, 3);

    // Reset mid-consultation with 3 queued.
    chk("t6_busy_before", busy_a, 1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t6_busy_a", busy_a, 0);
    chk("t6_count", queue_count, 0);
    chk("t6_token", token, 0);
    arr(2'b10); tick(); arrive = 1'b0;
    chk("t6_accept", accept, 1);
    chk("t6_new_token", token, 0);
    on_duty_a = 1'b1; on_duty_b = 1'b1;
    tick();
    chk("t6_valid", assign_valid, 1);
    chk("t6_doc", assign_doc, 1);
    chk("t6_atok", assign_token, 0);
    repeat (5) tick();

    // Token wrap: tokens 1..15 then 0 again.
    for (int i = 1; i <= 16; i++) begin
      arr(2'b00); tick(); arrive = 1'b0;
      chk("t7_wrap_token", token, i % 16);
      repeat (5) tick();
    end
    chk("t7_drained", queue_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
